// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that unpacks a framed byte stream
// into big-endian words written to instruction memory.
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   ByteIn, ByteValid, ByteReady  byte stream with valid/ready handshake
//   IMemWrite, IMemAddress,       registered one-cycle word write
//   IMemWriteData
//   CpuRst, Done, Error           pipeline reset and sticky load status
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        IMemWrite,
  output logic [31:0] IMemAddress,
  output logic [31:0] IMemWriteData,
  output logic        CpuRst,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] MaxW = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  xor_q, xor_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic [15:0] n_hdr;
  logic [15:0] word_inc;

  assign ByteReady = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept    = ByteValid && ByteReady;
  assign n_hdr     = {cnt_q[15:8], ByteIn};
  assign word_inc  = word_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    byte_d  = byte_q;
    asm_d   = asm_q;
    xor_d   = xor_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          cnt_d   = {ByteIn, 8'h00};
          xor_d   = xor_q ^ ByteIn;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          cnt_d = n_hdr;
          xor_d = xor_q ^ ByteIn;
          if ({1'b0, n_hdr} > MaxW)
            state_d = S_ERROR;
          else if (n_hdr == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ ByteIn;
          asm_d  = {asm_q[15:0], ByteIn};
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            wr_d    = 1'b1;
            wdata_d = {asm_q, ByteIn};
            // 32-bit add; wraps modulo 2^32 by construction
            addr_d  = BASE_ADDR + {14'd0, word_q, 2'b00};
            word_d  = word_inc;
            if (word_inc == cnt_q)
              state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept)
          state_d = (ByteIn == xor_q) ? S_DONE : S_ERROR;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_HDR_HI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_HDR_HI;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      asm_q   <= '0;
      xor_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      asm_q   <= asm_d;
      xor_q   <= xor_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign IMemWrite     = wr_q;
  assign IMemAddress   = addr_q;
  assign IMemWriteData = wdata_q;
  assign CpuRst        = (state_q != S_DONE);
  assign Done          = (state_q == S_DONE);
  assign Error         = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames checked against a
// frame-level reference model of the loader.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        IMemWrite;
  logic [31:0] IMemAddress;
  logic [31:0] IMemWriteData;
  logic        CpuRst;
  logic        Done;
  logic        Error;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .Clk(Clk), .Rst(Rst),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .IMemWrite(IMemWrite), .IMemAddress(IMemAddress),
    .IMemWriteData(IMemWriteData),
    .CpuRst(CpuRst), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t        mon_q[$];
  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  logic [31:0] wds[$];
  int         acc_cyc[$];
  int         n_tests = 0;
  int         n_fail = 0;

  always @(negedge Clk) begin
    if (IMemWrite) begin
      wr_t w;
      w.a = IMemAddress;
      w.d = IMemWriteData;
      w.c = cyc;
      mon_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level expectation: which bytes get accepted, which words
  // land where (tagged with the index of their 4th byte), final status.
  task automatic model(output int acc, output bit done, output bit err);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = {frame_q[0], frame_q[1]};
    if (n > MAXW) begin
      acc = 2; done = 0; err = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 4 * n + 2; i++) x ^= frame_q[i];
    for (int k = 0; k < n; k++) begin
      wr_t w;
      w.a = BASE + 32'(4 * k);
      w.d = {frame_q[2+4*k], frame_q[3+4*k],
             frame_q[4+4*k], frame_q[5+4*k]};
      w.c = 4 * k + 5;
      exp_q.push_back(w);
    end
    acc  = 4 * n + 3;
    done = (frame_q[4*n+2] == x);
    err  = !done;
  endtask

  task automatic build(input int n, input bit bad);
    logic [7:0] x;
    logic [15:0] n16;
    n16 = 16'(n);
    frame_q.delete();
    frame_q.push_back(n16[15:8]);
    frame_q.push_back(n16[7:0]);
    if (n <= MAXW) begin
      for (int k = 0; k < n; k++)
        for (int b = 3; b >= 0; b--)
          frame_q.push_back(8'(wds[k] >> (8 * b)));
      x = 8'h00;
      foreach (frame_q[i]) x ^= frame_q[i];
      if (bad) x ^= 8'($urandom_range(1, 255));
      frame_q.push_back(x);
    end else begin
      for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    ByteValid = 1'b1;
    ByteIn = 8'($urandom);
    @(posedge Clk); #1;
    Rst = 1'b0;
    ByteValid = 1'b0;
    chk("rst_wr", IMemWrite, 1'b0);
    chk("rst_addr", IMemAddress, BASE);
    chk("rst_wdata", IMemWriteData, 32'h0);
    chk("rst_ready", ByteReady, 1'b1);
    chk("rst_cpurst", CpuRst, 1'b1);
    chk("rst_done", Done, 1'b0);
    chk("rst_err", Error, 1'b0);
    mon_q.delete();
  endtask

  task automatic run_frame(input string tag, input int maxgap);
    int acc;
    bit done, err;
    int t;
    model(acc, done, err);
    acc_cyc.delete();
    mon_q.delete();
    for (int i = 0; i < acc; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        ByteValid = 1'b0;
        ByteIn = 8'($urandom);
        @(posedge Clk); #1;
      end
      ByteValid = 1'b1;
      ByteIn = frame_q[i];
      t = 0;
      while (!ByteReady && t < 8) begin
        @(posedge Clk); #1;
        t++;
      end
      if (!ByteReady) begin
        chk({tag, "_ready_to"}, ByteReady, 1'b1);
        ByteValid = 1'b0;
        return;
      end
      if (i == acc - 1) begin
        chk({tag, "_pre_done"}, Done, 1'b0);
        chk({tag, "_pre_err"}, Error, 1'b0);
      end
      acc_cyc.push_back(cyc + 1);
      @(posedge Clk); #1;
    end
    ByteValid = 1'b0;
    chk({tag, "_done"}, Done, done);
    chk({tag, "_err"}, Error, err);
    chk({tag, "_cpurst"}, CpuRst, !done);
    chk({tag, "_ready"}, ByteReady, 1'b0);
    repeat (3) begin
      ByteValid = 1'b1;
      ByteIn = 8'($urandom);
      @(posedge Clk); #1;
    end
    ByteValid = 1'b0;
    @(posedge Clk); #1;
    chk({tag, "_sticky"}, {Done, Error, CpuRst}, {done, err, !done});
    chk({tag, "_nwr"}, mon_q.size(), exp_q.size());
    if (mon_q.size() == exp_q.size()) begin
      foreach (exp_q[k]) begin
        chk({tag, "_addr"}, mon_q[k].a, exp_q[k].a);
        chk({tag, "_data"}, mon_q[k].d, exp_q[k].d);
        chk({tag, "_wcyc"}, mon_q[k].c, acc_cyc[exp_q[k].c]);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_frame("one", 0);
    if (mon_q.size() == 1)
      chk("one_lit", mon_q[0].d, 32'h2008_0005);
    else
      chk("one_cnt", mon_q.size(), 1);

    do_reset();
    wds = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    build(3, 0);
    chk("three_cs", frame_q[14], 8'h03);
    run_frame("three", 3);

    do_reset();
    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    run_frame("badcs", 1);

    do_reset();
    frame_q = '{8'h00, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_frame("over", 0);

    do_reset();
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", 0);

    do_reset();
    frame_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    foreach (frame_q[i]) begin
      ByteValid = 1'b1;
      ByteIn = frame_q[i];
      @(posedge Clk); #1;
    end
    do_reset();
    repeat (6) @(posedge Clk);
    #1;
    chk("abort_nwr", mon_q.size(), 0);
    frame_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_frame("after_rst", 1);

    for (int f = 0; f < 40; f++) begin
      int n;
      do_reset();
      n = $urandom_range(0, MAXW + 1);
      wds.delete();
      for (int k = 0; k < n; k++) wds.push_back($urandom);
      build(n, ($urandom_range(0, 3) == 0));
      run_frame("rnd", 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
